// File: rtl/mems_poller_pkg.sv
// mems_poller_pkg: register map, FSM encoding and master address helper shared by the poller
package mems_poller_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_XY     = 2'd2;
    localparam logic [1:0] REG_Z      = 2'd3;

    // controller address prefix: read access, 16-bit transfer
    localparam logic [1:0] MW_PREFIX  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CACK,
        ST_WDONE,
        ST_RD,
        ST_RACK,
        ST_PUB
    } state_t;

    function automatic logic [7:0] mw_addr(input logic [5:0] base, input logic [1:0] axis);
        return {MW_PREFIX, base + {3'b0, axis, 1'b0}};
    endfunction

endpackage

// File: rtl/mems_poller_timer.sv
// poll_timer: prescaler plus rate counter, one tick every (rate+1)*2^LGPRE clocks while enabled
module poll_timer #(
    parameter int LGPRE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] rate,
    output logic        tick
);

    logic [LGPRE-1:0] pre;
    logic [15:0]      cnt;

    assign tick = en && (&pre) && (cnt == rate);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (load || tick) begin
            pre <= '0;
            cnt <= '0;
        end else if (en) begin
            pre <= pre + LGPRE'(1);
            cnt <= (&pre) ? cnt + 16'd1 : cnt;
        end
    end

endmodule

// File: rtl/mems_poller.sv
// mems_poller: periodic X/Y/Z sampler mastering the MEMS SPI controller bus,
// publishing each complete triple atomically to a 4-word CPU slave port.
module mems_poller
    import mems_poller_pkg::*;
#(
    parameter int         LGPRE   = 8,
    parameter logic [5:0] X_REG   = 6'h28,
    parameter int         TIMEOUT = 4095
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_mw_cyc,
    output logic        o_mw_stb,
    output logic        o_mw_we,
    output logic [7:0]  o_mw_addr,
    output logic [31:0] o_mw_data,
    input  logic        i_mw_ack,
    input  logic        i_mw_stall,
    input  logic [31:0] i_mw_data,
    input  logic        i_mems_done,
    output logic        o_int
);

    state_t            state, nxt;
    logic              en, trig, err, fresh, abort;
    logic [15:0]       rate, seq;
    logic [7:0]        ovr;
    logic [1:0]        axis;
    logic [11:0]       to_cnt;
    logic [2:0][15:0]  shadow, vis;
    logic              tick, start, idle, stop, to_exp, pub;
    logic              wr, rd, ctrl_wr, stat_wr, z_rd, abort_set;
    logic [31:0]       rdata;
    logic              unused;

    assign unused    = ^{i_wb_data[15:2], i_mw_data[31:16]};
    assign wr        = i_wb_cyc && i_wb_stb && i_wb_we;
    assign rd        = i_wb_cyc && i_wb_stb && !i_wb_we;
    assign ctrl_wr   = wr && (i_wb_addr == REG_CTRL);
    assign stat_wr   = wr && (i_wb_addr == REG_STATUS);
    assign z_rd      = rd && (i_wb_addr == REG_Z);
    assign idle      = (state == ST_IDLE);
    assign start     = tick || trig;
    // clearing en only aborts a sequence that was running with en set
    assign abort_set = ctrl_wr && !i_wb_data[0] && en && !idle;
    assign stop      = abort || abort_set;
    assign pub       = (state == ST_PUB) && !stop;

    poll_timer #(.LGPRE(LGPRE)) u_timer (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .en    (en),
        .load  (ctrl_wr),
        .rate  (rate),
        .tick  (tick)
    );

    always_comb begin
        nxt    = state;
        to_exp = 1'b0;
        case (state)
            ST_IDLE:  nxt = start ? ST_CMD : ST_IDLE;
            ST_CMD:   nxt = i_mw_stall ? ST_CMD : ST_CACK;
            ST_CACK:  nxt = !i_mw_ack ? ST_CACK : stop ? ST_IDLE : ST_WDONE;
            ST_WDONE: begin
                to_exp = !stop && !i_mems_done && (to_cnt == 12'(TIMEOUT));
                nxt    = (stop || to_exp) ? ST_IDLE : i_mems_done ? ST_RD : ST_WDONE;
            end
            ST_RD:    nxt = i_mw_stall ? ST_RD : ST_RACK;
            ST_RACK:  nxt = !i_mw_ack ? ST_RACK : stop ? ST_IDLE : (axis == 2'd2) ? ST_PUB : ST_CMD;
            ST_PUB:   nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            axis   <= '0;
            to_cnt <= '0;
            abort  <= 1'b0;
            shadow <= '0;
        end else begin
            state  <= nxt;
            to_cnt <= (state == ST_WDONE) ? to_cnt + 12'd1 : '0;
            abort  <= idle ? 1'b0 : stop;
            if (idle)
                axis <= '0;
            else if (state == ST_RACK && i_mw_ack) begin
                shadow[axis] <= i_mw_data[15:0];
                axis         <= axis + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            en    <= 1'b0;
            trig  <= 1'b0;
            rate  <= '0;
            err   <= 1'b0;
            ovr   <= '0;
            fresh <= 1'b0;
            seq   <= '0;
            vis   <= '0;
        end else begin
            en    <= ctrl_wr ? i_wb_data[0] : en;
            rate  <= ctrl_wr ? i_wb_data[31:16] : rate;
            trig  <= ctrl_wr && i_wb_data[1];
            err   <= to_exp || (err && !stat_wr);
            ovr   <= stat_wr ? '0 : (start && !idle && !stop && ovr != 8'hFF) ? ovr + 8'd1 : ovr;
            fresh <= pub ? 1'b1 : z_rd ? 1'b0 : fresh;
            seq   <= pub ? seq + 16'd1 : seq;
            vis   <= pub ? shadow : vis;
        end
    end

    always_comb begin
        rdata = (i_wb_addr == REG_CTRL)   ? {rate, 14'b0, trig, en} :
                (i_wb_addr == REG_STATUS) ? {16'b0, ovr, 5'b0, err, fresh, !idle} :
                (i_wb_addr == REG_XY)     ? {vis[1], vis[0]} : {seq, vis[2]};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= i_wb_cyc && i_wb_stb;
            o_wb_data <= (i_wb_cyc && i_wb_stb) ? rdata : o_wb_data;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_mw_cyc   = (state == ST_CMD) || (state == ST_CACK) || (state == ST_RD) || (state == ST_RACK);
    assign o_mw_stb   = (state == ST_CMD) || (state == ST_RD);
    assign o_mw_we    = (state == ST_CMD);
    assign o_mw_addr  = o_mw_cyc ? mw_addr(X_REG, axis) : '0;
    assign o_mw_data  = '0;
    assign o_int      = fresh;

endmodule

// File: tb/tb_mems_poller.sv
// tb_mems_poller: directed checks of mems_poller against a simple controller bus model
module tb_mems_poller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [1:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic        mw_cyc, mw_stb, mw_we;
    logic [7:0]  mw_addr;
    logic [31:0] mw_wdata;
    logic        mw_ack, mw_stall = 1'b0;
    logic [31:0] mw_rdata;
    logic        done;
    logic        irq;

    int          total = 0;
    int          bad = 0;
    logic [15:0] xv, yv, zv;
    int          done_dly = 0;
    logic        done_en = 1'b1;
    logic        pend;
    int          dcnt;
    logic [8:0]  log_q[$];
    logic [31:0] rv;
    int          n;
    logic [8:0]  exp_log [6] = '{9'h1E8, 9'h0E8, 9'h1EA, 9'h0EA, 9'h1EC, 9'h0EC};

    mems_poller #(.LGPRE(2)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_wb_cyc    (wb_cyc),
        .i_wb_stb    (wb_stb),
        .i_wb_we     (wb_we),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_wdata),
        .o_wb_ack    (wb_ack),
        .o_wb_stall  (wb_stall),
        .o_wb_data   (wb_rdata),
        .o_mw_cyc    (mw_cyc),
        .o_mw_stb    (mw_stb),
        .o_mw_we     (mw_we),
        .o_mw_addr   (mw_addr),
        .o_mw_data   (mw_wdata),
        .i_mw_ack    (mw_ack),
        .i_mw_stall  (mw_stall),
        .i_mw_data   (mw_rdata),
        .i_mems_done (done),
        .o_int       (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] axis_val(input logic [5:0] a);
        return (a == 6'h28) ? xv : (a == 6'h2A) ? yv : (a == 6'h2C) ? zv : 16'hDEAD;
    endfunction

    // controller model: ack one cycle after each request, done pulse done_dly+1 clocks after write ack
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_ack   <= 1'b0;
            done     <= 1'b0;
            pend     <= 1'b0;
            dcnt     <= 0;
            mw_rdata <= '0;
        end else begin
            mw_ack <= mw_cyc && mw_stb;
            done   <= 1'b0;
            if (pend && done_en) begin
                if (dcnt == 0) begin
                    done <= 1'b1;
                    pend <= 1'b0;
                end else
                    dcnt <= dcnt - 1;
            end
            if (mw_cyc && mw_stb) begin
                log_q.push_back({mw_we, mw_addr});
                if (mw_we) begin
                    pend <= 1'b1;
                    dcnt <= done_dly;
                end else
                    mw_rdata <= {16'h0, axis_val(mw_addr[5:0])};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("wb_ack", {31'b0, wb_ack}, 32'd1);
        d = wb_rdata;
    endtask

    task automatic wait_int(input string tag, input int lim);
        n = 0;
        while (!irq && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, irq}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cyc", {31'b0, mw_cyc}, 32'd0);
        check("rst_int", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        wb_read(2'd0, rv); check("rst_ctrl", rv, 32'h0);
        wb_read(2'd1, rv); check("rst_status", rv, 32'h0);
        wb_read(2'd2, rv); check("rst_xy", rv, 32'h0);
        wb_read(2'd3, rv); check("rst_z", rv, 32'h0);

        // 1: first sample, tick after 16 clocks
        xv = 16'h0102; yv = 16'h0304; zv = 16'h0506;
        wb_write(2'd0, {16'd3, 16'h0001});
        n = 0;
        while (!mw_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_first_tick", n, 32'd16);
        wait_int("t1_int", 100);
        wb_read(2'd2, rv); check("t1_xy", rv, 32'h03040102);
        wb_read(2'd3, rv); check("t1_z", rv, 32'h00010506);
        check("t1_int_clr", {31'b0, irq}, 32'd0);
        wb_read(2'd1, rv); check("t1_status_ovr", rv, 32'h00000100);
        wb_write(2'd0, 32'h0);

        // 2: second period, bus transaction order
        wb_write(2'd1, 32'h0);
        log_q.delete();
        xv = 16'h1111; yv = 16'h2222; zv = 16'h3333;
        wb_write(2'd0, {16'd3, 16'h0001});
        wait_int("t2_int", 100);
        check("t2_log_size", log_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size())
                check($sformatf("t2_log%0d", i), {23'b0, log_q[i]}, {23'b0, exp_log[i]});
        end
        wb_read(2'd2, rv); check("t2_xy", rv, 32'h22221111);
        wb_read(2'd3, rv); check("t2_z", rv, 32'h00023333);
        check("t2_int_clr", {31'b0, irq}, 32'd0);
        wb_write(2'd0, 32'h0);
        wb_write(2'd1, 32'h0);

        // 3: R=0 with slow done, ticks dropped while busy
        xv = 16'h0A0A; yv = 16'h0B0B; zv = 16'h0C0C;
        done_dly = 20;
        wb_write(2'd0, {16'd0, 16'h0001});
        wait_int("t3_int", 200);
        wb_read(2'd1, rv); check("t3_status_ovr", rv, 32'h00001302);
        wb_write(2'd0, 32'h0);
        wb_write(2'd1, 32'h0);
        wb_read(2'd1, rv); check("t3_ovr_clr", rv, 32'h00000002);
        wb_read(2'd3, rv); check("t3_z", rv, 32'h00030C0C);
        check("t3_int_clr", {31'b0, irq}, 32'd0);

        // 4: done never arrives, timeout after TIMEOUT+1 clocks in WDONE
        done_en = 1'b0;
        wb_write(2'd0, 32'h2);
        n = 0;
        while (!mw_cyc && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (mw_cyc && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_wdone", {31'b0, mw_cyc}, 32'd0);
        repeat (4090) @(negedge clk);
        wb_read(2'd1, rv); check("t4_before_to", rv, 32'h00000001);
        repeat (10) @(negedge clk);
        wb_read(2'd1, rv); check("t4_err", rv, 32'h00000004);
        wb_read(2'd2, rv); check("t4_xy_kept", rv, 32'h0B0B0A0A);
        wb_read(2'd3, rv); check("t4_z_kept", rv, 32'h00030C0C);
        check("t4_int", {31'b0, irq}, 32'd0);

        // 5: en cleared while waiting for Y done
        done_en = 1'b1;
        wb_write(2'd1, 32'h0);
        log_q.delete();
        wb_write(2'd0, 32'hFFFF_0003);
        n = 0;
        while (!(mw_cyc && mw_we && mw_addr == 8'hEA) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_y_cmd", {24'b0, mw_addr}, 32'hEA);
        n = 0;
        while (mw_cyc && n < 10) begin
            @(negedge clk);
            n++;
        end
        wb_write(2'd0, 32'h0);
        repeat (30) @(negedge clk);
        check("t5_log_size", log_q.size(), 32'd3);
        wb_read(2'd1, rv); check("t5_status", rv, 32'h0);
        wb_read(2'd3, rv); check("t5_z_kept", rv, 32'h00030C0C);
        check("t5_int", {31'b0, irq}, 32'd0);

        // 6: trigger with en=0 runs exactly once, then reset mid-read
        done_dly = 0;
        xv = 16'h4444; yv = 16'h5555; zv = 16'h6666;
        log_q.delete();
        wb_write(2'd0, 32'h2);
        wait_int("t6_int", 200);
        repeat (40) @(negedge clk);
        check("t6_log_size", log_q.size(), 32'd6);
        wb_read(2'd1, rv); check("t6_status", rv, 32'h00000002);
        wb_read(2'd2, rv); check("t6_xy", rv, 32'h55554444);
        wb_read(2'd3, rv); check("t6_z", rv, 32'h00046666);
        wb_write(2'd0, 32'h2);
        n = 0;
        while (!(mw_stb && !mw_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_rd", {31'b0, mw_stb && !mw_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", {31'b0, mw_cyc}, 32'd0);
        check("t6_rst_stb", {31'b0, mw_stb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_read(2'd0, rv); check("t6_ctrl", rv, 32'h0);
        wb_read(2'd1, rv); check("t6_status0", rv, 32'h0);
        wb_read(2'd2, rv); check("t6_xy0", rv, 32'h0);
        wb_read(2'd3, rv); check("t6_z0", rv, 32'h0);
        check("t6_int0", {31'b0, irq}, 32'd0);
        repeat (5) @(negedge clk);
        check("t6_idle_cyc", {31'b0, mw_cyc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
